fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
// Drain stage directly downstream of the synchronous FIFO (clock, resetn, wr_en, rd_en, data_in -> full, empty, data_out).
// Issues FIFO reads and absorbs the FIFO read latency in a small registered output buffer.
// Presents the FIFO contents as a valid/ready stream, in order, with no loss and no duplication.
// Sustains one word/cycle when BUF_DEPTH >= RD_LATENCY+2. Provides a synchronous flush.
// PARAMETERS
// DATA_WIDTH  32  width of FIFO data and stream data
// RD_LATENCY  1   cycles from fifo_rd_en high to fifo_rdata valid; legal values 0 (first-word fall-through) or 1
// BUF_DEPTH   3   output buffer entries; legal range 2..8
// PORTS
// clock       in   1                      single clock; all state changes on its rising edge
// resetn      in   1                      asynchronous, active-low reset
// fifo_empty  in   1                      FIFO empty flag
// fifo_rdata  in   DATA_WIDTH             FIFO data_out
// fifo_rd_en  out  1                      FIFO read strobe (one word popped per high cycle)
// m_valid     out  1                      stream data valid
// m_ready     in   1                      stream consumer ready
// m_data      out  DATA_WIDTH             stream data (head of output buffer)
// flush       in   1                      synchronous flush of buffered and in-flight words
// occupancy   out  $clog2(BUF_DEPTH+1)    words currently held in the output buffer
// BEHAVIOUR
// - Reset (resetn=0, async): m_valid=0, m_data=0, occupancy=0, in-flight count=0, pointers=0, drop count=0.
// - fifo_rd_en is forced 0 while resetn=0.
// - Storage: circular buffer of BUF_DEPTH entries with wr_ptr/rd_ptr and occupancy counter. Pointers wrap BUF_DEPTH-1 -> 0; BUF_DEPTH need not be a power of 2.
// - Issue rule: fifo_rd_en = !fifo_empty && !flush && (occupancy + inflight) < BUF_DEPTH.
//   - inflight = reads issued whose data is not yet captured: 0..RD_LATENCY.
//   - fifo_rd_en has no combinational dependence on m_ready.
// - Capture: a read issued in cycle N has its data sampled from fifo_rdata at the rising edge ending cycle N+RD_LATENCY.
//   - It is written at wr_ptr and is visible on m_data with m_valid=1 from cycle N+RD_LATENCY+1.
//   - FIFO-empty-to-m_valid latency: RD_LATENCY+1 cycles.
// - Stream: m_valid = (occupancy != 0); m_data = buf[rd_ptr] (registered storage, no path from fifo_rdata).
//   - Pop on m_valid && m_ready: rd_ptr++ and occupancy-- at that edge.
//   - m_data/m_valid hold stable while m_valid && !m_ready.
// - Simultaneous capture and pop in one cycle: occupancy unchanged, both pointers advance.
//   - Capture when full cannot occur (guaranteed by the issue rule); add an assertion.
// - Flush (flush=1 at an edge):
//   - occupancy and pointers -> 0, m_valid=0 the next cycle; a pop in the same cycle is discarded.
//   - fifo_rd_en=0 during flush.
//   - Words already in flight are discarded on arrival: a drop counter is loaded with inflight and decremented per arrival; captures are suppressed while it is nonzero.
//   - The FIFO itself is not flushed. Reads resume in the first cycle after flush deasserts.
// - Reset mid-operation: all state clears immediately.
//   - Words already popped from the FIFO are lost; this is the upstream owner's concern.
// - Ordering: words leave m_data in exact FIFO pop order.
// TESTING
// 1. Reset: resetn=0 for 10 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, occupancy=0 throughout; after release, first fifo_rd_en in the next cycle.
// 2. Streaming (RD_LATENCY=1, BUF_DEPTH=3): FIFO preloaded with 30 $urandom words, m_ready=1 -> fifo_rd_en high every cycle, m_valid continuous after 2 cycles, data matches a scoreboard queue in order.
// 3. Backpressure: m_ready=0 with 10 words in the FIFO -> exactly 3 reads issued, occupancy=3, fifo_rd_en=0, m_data stable; m_ready=1 -> remaining 7 words drain in order, none lost.
// 4. Alternating: FIFO writes on even cycles and m_ready on even cycles for 30 cycles, twice -> every popped word equals the scoreboard front; no underflow or duplicates.
// 5. Flush: occupancy=2 with 1 in flight, pulse flush for 1 cycle -> m_valid=0 next cycle, the in-flight word is dropped, the next word out equals FIFO word #4.
// 6. RD_LATENCY=0, BUF_DEPTH=2: fifo_empty falls at cycle N -> m_valid=1 at N+1 with m_data equal to the FIFO head; sustained throughput of 1 word/cycle with m_ready=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a valid/ready stream.
// FIFO read latency is absorbed by a small registered circular output buffer.
// Reads are issued only when the buffer is guaranteed to have room for them.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_rdata,
    output logic                             fifo_rd_en,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    input  logic                             flush,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]       occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q, drop_d;

    logic inflight;
    logic arrival;
    logic capture;
    logic pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue, arrival, capture and pop decisions for the current cycle.
    always_comb begin
        inflight   = (RD_LATENCY == 0) ? 1'b0 : inflight_q;
        fifo_rd_en = resetn && !fifo_empty && !flush
                     && ((32'(occ_q) + 32'(inflight)) < BUF_DEPTH);
        // With zero latency the word is on fifo_rdata in the issuing cycle.
        arrival    = (RD_LATENCY == 0) ? fifo_rd_en : inflight_q;
        capture    = arrival && !drop_q && !flush;
        m_valid    = (occ_q != '0);
        pop        = m_valid && m_ready && !flush;
        m_data     = mem_q[rd_ptr_q];
        occupancy  = occ_q;
    end

    // Next-state for pointers, occupancy, in-flight tracking and drop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        inflight_d = (RD_LATENCY == 0) ? 1'b0 : fifo_rd_en;
        drop_d     = drop_q;
        if (arrival && drop_q) begin
            drop_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            // The word arriving at the flush edge is discarded by the flush itself;
            // only reads still outstanding beyond this edge need dropping later.
            drop_d   = inflight_d;
        end else begin
            if (capture) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (capture && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !capture) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Output buffer storage; cleared on reset so m_data reads zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (capture) begin
            mem_q[wr_ptr_q] <= fifo_rdata;
        end
    end

    // The issue rule must never let a word arrive into a full buffer.
    assert property (@(posedge clock) disable iff (!resetn)
        capture |-> (occ_q < OccW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one instance with RD_LATENCY=1/BUF_DEPTH=3 and one with
// RD_LATENCY=0/BUF_DEPTH=2, each fed by a behavioural FIFO model.
module tb_fifo_stream_reader;

    logic        clock = 1'b0;
    logic        resetn;

    // Instance 1: RD_LATENCY=1, BUF_DEPTH=3
    logic        f1_empty = 1'b1;
    logic [31:0] f1_rdata = '0;
    logic        f1_rd_en;
    logic        m1_valid;
    logic        m1_ready;
    logic [31:0] m1_data;
    logic        flush1;
    logic [1:0]  occ1;

    // Instance 0: RD_LATENCY=0, BUF_DEPTH=2
    logic        f0_empty = 1'b1;
    logic [31:0] f0_rdata = '0;
    logic        f0_rd_en;
    logic        m0_valid;
    logic        m0_ready;
    logic [31:0] m0_data;
    logic        flush0;
    logic [1:0]  occ0;

    logic [31:0] fq1[$];
    logic [31:0] sb1[$];
    logic [31:0] fq0[$];
    logic [31:0] sb0[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pops1    = 0;

    typedef struct {
        logic        push;
        logic [31:0] wdata;
        logic        ready;
        logic        flush;
        logic        exp_rd_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t vt[13];

    always #5 clock = ~clock;

    fifo_stream_reader #(
        .DATA_WIDTH (32),
        .RD_LATENCY (1),
        .BUF_DEPTH  (3)
    ) dut1 (
        .clock      (clock),
        .resetn     (resetn),
        .fifo_empty (f1_empty),
        .fifo_rdata (f1_rdata),
        .fifo_rd_en (f1_rd_en),
        .m_valid    (m1_valid),
        .m_ready    (m1_ready),
        .m_data     (m1_data),
        .flush      (flush1),
        .occupancy  (occ1)
    );

    fifo_stream_reader #(
        .DATA_WIDTH (32),
        .RD_LATENCY (0),
        .BUF_DEPTH  (2)
    ) dut0 (
        .clock      (clock),
        .resetn     (resetn),
        .fifo_empty (f0_empty),
        .fifo_rdata (f0_rdata),
        .fifo_rd_en (f0_rd_en),
        .m_valid    (m0_valid),
        .m_ready    (m0_ready),
        .m_data     (m0_data),
        .flush      (flush0),
        .occupancy  (occ0)
    );

    // FIFO model with one cycle read latency.
    always @(posedge clock) begin
        if (f1_rd_en && fq1.size() > 0) begin
            f1_rdata <= fq1[0];
            #1;
            void'(fq1.pop_front());
            f1_empty = (fq1.size() == 0);
        end
    end

    // First-word fall-through FIFO model.
    always @(posedge clock) begin
        if (f0_rd_en && fq0.size() > 0) begin
            #1;
            void'(fq0.pop_front());
            f0_empty = (fq0.size() == 0);
            f0_rdata = (fq0.size() > 0) ? fq0[0] : '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [31:0] w);
        fq1.push_back(w);
        sb1.push_back(w);
        f1_empty = 1'b0;
    endtask

    task automatic push0(input logic [31:0] w);
        fq0.push_back(w);
        sb0.push_back(w);
        f0_empty = 1'b0;
        f0_rdata = fq0[0];
    endtask

    // Called #1 after a negedge: score a pop on instance 1 if one happens this cycle.
    task automatic sample1(input string name);
        if (m1_valid && m1_ready && !flush1) begin
            pops1++;
            if (sb1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s underflow: got %h, expected no word", name, m1_data);
            end else begin
                check(name, m1_data, sb1.pop_front());
            end
        end
    endtask

    initial begin
        int          reads;
        logic        seen;
        logic [31:0] w4;

        vt[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vt[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vt[2]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd1};
        vt[3]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2};
        vt[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd3};
        vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd3};
        vt[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 2'd2};
        vt[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA3, 2'd1};
        vt[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA3, 2'd2};
        vt[9]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA4, 2'd1};
        vt[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0};
        vt[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hA5, 2'd1};
        vt[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0};

        resetn   = 1'b1;
        m1_ready = 1'b1;
        m0_ready = 1'b1;
        flush1   = 1'b0;
        flush0   = 1'b0;
        #2 resetn = 1'b0;

        // Reset held 10 cycles with a full FIFO behind it, then streaming.
        for (int i = 0; i < 30; i++) begin
            push1($urandom);
        end
        @(negedge clock);
        for (int c = 0; c < 10; c++) begin
            #1;
            check("reset rd_en", f1_rd_en, 1'b0);
            check("reset valid", m1_valid, 1'b0);
            check("reset occ", occ1, 2'd0);
            @(negedge clock);
        end
        check("reset m_data", m1_data, 32'h0);
        resetn = 1'b1;
        for (int c = 0; c < 34; c++) begin
            #1;
            if (c < 30) check($sformatf("stream rd_en c%0d", c), f1_rd_en, 1'b1);
            if (c >= 2 && c < 32) begin
                check($sformatf("stream valid c%0d", c), m1_valid, 1'b1);
                sample1($sformatf("stream data c%0d", c));
            end
            if (c >= 32) check("stream tail valid", m1_valid, 1'b0);
            @(negedge clock);
        end
        check("stream sb empty", sb1.size(), 0);

        // Table-driven cycle vectors from a fresh reset.
        resetn = 1'b0;
        #1;
        check("async reset m_data", m1_data, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            m1_ready = vt[i].ready;
            flush1   = vt[i].flush;
            if (vt[i].push) push1(vt[i].wdata);
            #1;
            check($sformatf("vec%0d rd_en", i), f1_rd_en, vt[i].exp_rd_en);
            check($sformatf("vec%0d valid", i), m1_valid, vt[i].exp_valid);
            check($sformatf("vec%0d occ", i), occ1, vt[i].exp_occ);
            if (vt[i].exp_valid) check($sformatf("vec%0d data", i), m1_data, vt[i].exp_data);
            @(negedge clock);
        end
        flush1 = 1'b0;
        sb1.delete();

        // Backpressure: 10 words, consumer stalled.
        m1_ready = 1'b0;
        for (int i = 0; i < 10; i++) push1($urandom);
        reads = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (f1_rd_en) reads++;
            if (m1_valid) check("bp stable data", m1_data, sb1[0]);
            @(negedge clock);
        end
        #1;
        check("bp reads", reads, 3);
        check("bp occ", occ1, 2'd3);
        check("bp rd_en", f1_rd_en, 1'b0);
        @(negedge clock);
        m1_ready = 1'b1;
        pops1 = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            sample1("bp drain");
            @(negedge clock);
        end
        check("bp pops", pops1, 10);
        check("bp sb empty", sb1.size(), 0);

        // Alternating writes and ready, two rounds of 30 cycles.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 30; c++) begin
                m1_ready = (c % 2 == 0);
                if (c % 2 == 0) push1($urandom);
                #1;
                sample1("alt pop");
                @(negedge clock);
            end
        end
        m1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            sample1("alt drain");
            @(negedge clock);
        end
        check("alt sb empty", sb1.size(), 0);

        // Flush with two words buffered and one in flight.
        m1_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1($urandom);
        w4 = sb1[3];
        #1;
        @(negedge clock);
        #1;
        @(negedge clock);
        #1;
        check("flush pre rd_en", f1_rd_en, 1'b1);
        @(negedge clock);
        flush1 = 1'b1;
        #1;
        check("flush occ before", occ1, 2'd2);
        check("flush rd_en", f1_rd_en, 1'b0);
        @(negedge clock);
        flush1 = 1'b0;
        #1;
        check("flush valid after", m1_valid, 1'b0);
        check("flush occ after", occ1, 2'd0);
        for (int i = 0; i < 3; i++) void'(sb1.pop_front());
        @(negedge clock);
        m1_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m1_valid && !seen) begin
                seen = 1'b1;
                check("flush next word", m1_data, w4);
            end
            sample1("flush drain");
            @(negedge clock);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL flush next word: got no valid, expected %h", w4);
        end
        check("flush sb empty", sb1.size(), 0);

        // Zero-latency instance: empty-to-valid latency and full throughput.
        push0($urandom);
        #1;
        check("rl0 rd_en", f0_rd_en, 1'b1);
        check("rl0 valid early", m0_valid, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 10; i++) push0($urandom);
        #1;
        check("rl0 first valid", m0_valid, 1'b1);
        check("rl0 first data", m0_data, sb0.pop_front());
        for (int c = 2; c < 13; c++) begin
            if (c <= 11) check($sformatf("rl0 rd_en c%0d", c - 1), f0_rd_en, 1'b1);
            @(negedge clock);
            #1;
            if (c <= 11) begin
                check($sformatf("rl0 valid c%0d", c), m0_valid, 1'b1);
                if (sb0.size() > 0) check($sformatf("rl0 data c%0d", c), m0_data, sb0.pop_front());
            end else begin
                check("rl0 tail valid", m0_valid, 1'b0);
            end
        end
        check("rl0 sb empty", sb0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
